// File: rtl/riscv_pkg.sv
// Shared front-end definitions: datapath width, PC increment, reset vector
// and the fetch controller state encoding.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        REQ  = 2'd2
    } pc_fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch request controller with redirect buffering.
// Optional fetch/redirect statistics counters are built when PC_FETCH_STATS_EN is defined.
module pc_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int                          XLEN         = riscv_pkg::XLEN,
    parameter logic [riscv_pkg::XLEN-1:0]  RESET_VECTOR = riscv_pkg::RESET_VECTOR,
    parameter int                          INSTR_BYTES  = riscv_pkg::INSTR_BYTES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] branch_target,
    input  logic            branch_taken,
    input  logic            stall,
    output logic            if_req_valid,
    input  logic            if_req_ready,
    output logic [XLEN-1:0] if_req_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redirect_pending,
    output logic            misalign_err,
    output logic [31:0]     redirect_count,
    output logic [31:0]     fetch_count
);

    pc_fetch_state_t r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_target;
    logic            r_pend;
    logic            r_misalign;

    logic            w_handshake;
    logic            w_redirect_ok;
    logic            w_redirect_bad;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_hs_pc;

    assign w_handshake    = (r_state == REQ) && if_req_ready;
    assign w_redirect_ok  = branch_taken && (branch_target[1:0] == 2'b00);
    assign w_redirect_bad = branch_taken && (branch_target[1:0] != 2'b00);
    assign w_pc_plus4     = r_pc + XLEN'(INSTR_BYTES);

    // A live redirect beats a buffered one, which beats sequential flow.
    always_comb begin
        w_hs_pc = w_pc_plus4;
        if (w_redirect_ok) begin
            w_hs_pc = branch_target;
        end else if (r_pend) begin
            w_hs_pc = r_pend_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            case (r_state)
                BOOT:    r_state <= IDLE;
                IDLE:    if (!stall) r_state <= REQ;
                REQ:     if (w_handshake && stall) r_state <= IDLE;
                default: r_state <= BOOT;
            endcase
        end
    end

    // While a request is outstanding the address must stay stable, so
    // redirects are parked in the pending buffer until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_VECTOR;
            r_pend        <= 1'b0;
            r_pend_target <= '0;
        end else if (w_handshake) begin
            r_pc   <= w_hs_pc;
            r_pend <= 1'b0;
        end else if (w_redirect_ok) begin
            if (r_state == REQ) begin
                r_pend        <= 1'b1;
                r_pend_target <= branch_target;
            end else begin
                r_pc <= branch_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redirect_bad;
        end
    end

`ifdef PC_FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count    <= 32'd0;
            r_redirect_count <= 32'd0;
        end else begin
            if (w_handshake) r_fetch_count <= r_fetch_count + 32'd1;
            if (w_redirect_ok) r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign fetch_count    = r_fetch_count;
    assign redirect_count = r_redirect_count;
`else
    assign fetch_count    = 32'd0;
    assign redirect_count = 32'd0;
`endif

    assign if_req_valid     = (r_state == REQ);
    assign if_req_addr      = r_pc;
    assign pc               = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign redirect_pending = r_pend;
    assign misalign_err     = r_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a scoreboard queue of expected fetch
// addresses is drained by a monitor on every handshake; side outputs are checked inline.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] branchTarget;
    logic        branchTaken;
    logic        stallIn;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;
    logic        redirectPending;
    logic        misalignErr;
    logic [31:0] redirectCount;
    logic [31:0] fetchCount;

    int checks = 0;
    int errors = 0;
    int expFetches = 0;
    int expRedirects = 0;
    logic [31:0] expQ[$];

    pc_fetch_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .branch_target    (branchTarget),
        .branch_taken     (branchTaken),
        .stall            (stallIn),
        .if_req_valid     (reqValid),
        .if_req_ready     (reqReady),
        .if_req_addr      (reqAddr),
        .pc               (pcOut),
        .pc_plus4         (pcPlus4),
        .redirect_pending (redirectPending),
        .misalign_err     (misalignErr),
        .redirect_count   (redirectCount),
        .fetch_count      (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every handshake must match the oldest address the stimulus expects.
    always @(negedge clk) begin
        if (rst_n && reqValid && reqReady) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL fetchAddr: unexpected handshake addr=%h, none expected", reqAddr);
            end else begin
                logic [31:0] exp;
                exp = expQ.pop_front();
                if (reqAddr !== exp) begin
                    errors++;
                    $display("[TB] FAIL fetchAddr: got %h expected %h", reqAddr, exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushFetch(input logic [31:0] addr);
        expQ.push_back(addr);
        expFetches++;
    endtask

    // One cycle of an aligned or misaligned taken branch.
    task automatic applyStimulus(input logic [31:0] target);
        branchTaken  = 1'b1;
        branchTarget = target;
        if (target[1:0] == 2'b00) expRedirects++;
        tick();
        branchTaken  = 1'b0;
    endtask

    task automatic checkCounters(input string tag);
`ifdef PC_FETCH_STATS_EN
        checkOutput({tag, "FetchCount"}, fetchCount, 32'(expFetches));
        checkOutput({tag, "RedirectCount"}, redirectCount, 32'(expRedirects));
`else
        checkOutput({tag, "FetchCount"}, fetchCount, 32'd0);
        checkOutput({tag, "RedirectCount"}, redirectCount, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; reqReady = 1'b0; stallIn = 1'b0;
        branchTaken = 1'b0; branchTarget = 32'd0;
        tick(); tick();
        checkOutput("resetValid", 32'(reqValid), 32'd0);
        checkOutput("resetPc", pcOut, 32'h0);
        checkOutput("resetPcPlus4", pcPlus4, 32'h4);
        checkOutput("resetPending", 32'(redirectPending), 32'd0);
        checkOutput("resetMisalign", 32'(misalignErr), 32'd0);
        checkCounters("reset");

        // Streaming from the reset vector with ready held high.
        pushFetch(32'h0); pushFetch(32'h4);
        reqReady = 1'b1;
        rst_n = 1'b1;
        checkOutput("bootValid", 32'(reqValid), 32'd0);
        tick();
        checkOutput("idleValid", 32'(reqValid), 32'd0);
        tick();
        checkOutput("firstValid", 32'(reqValid), 32'd1);
        checkOutput("firstAddr", reqAddr, 32'h0);
        tick();
        checkOutput("secondAddr", reqAddr, 32'h4);
        tick();
        reqReady = 1'b0;
        checkOutput("thirdAddr", reqAddr, 32'h8);
        checkOutput("streamMisalign", 32'(misalignErr), 32'd0);

        // Backpressure at 0x8.
        for (int i = 0; i < 3; i++) begin
            checkOutput("bpValid", 32'(reqValid), 32'd1);
            checkOutput("bpAddr", reqAddr, 32'h8);
            tick();
        end
        pushFetch(32'h8); pushFetch(32'hC);
        reqReady = 1'b1;
        tick();
        checkOutput("afterBpAddr", reqAddr, 32'hC);
        tick();
        reqReady = 1'b0;
        checkOutput("reachAddr10", reqAddr, 32'h10);

        // Redirect while the request at 0x10 is stalled by memory.
        applyStimulus(32'h100);
        checkOutput("pendSet", 32'(redirectPending), 32'd1);
        checkOutput("pendAddrHold", reqAddr, 32'h10);
        tick();
        checkOutput("pendStillSet", 32'(redirectPending), 32'd1);
        checkOutput("pendAddrHold2", reqAddr, 32'h10);
        pushFetch(32'h10);
        reqReady = 1'b1;
        tick();
        reqReady = 1'b0;
        checkOutput("redirAddr", reqAddr, 32'h100);
        checkOutput("pendCleared", 32'(redirectPending), 32'd0);

        // Newest pending redirect wins.
        applyStimulus(32'h300);
        applyStimulus(32'h200);
        checkOutput("newestPend", 32'(redirectPending), 32'd1);
        checkOutput("newestAddrHold", reqAddr, 32'h100);
        pushFetch(32'h100);
        reqReady = 1'b1;
        tick();
        reqReady = 1'b0;
        checkOutput("newestAddr", reqAddr, 32'h200);
        checkCounters("redirect");

        // Misaligned target is dropped and flagged for one cycle.
        applyStimulus(32'h102);
        checkOutput("misalignPulse", 32'(misalignErr), 32'd1);
        checkOutput("misalignNoPend", 32'(redirectPending), 32'd0);
        checkOutput("misalignAddr", reqAddr, 32'h200);
        tick();
        checkOutput("misalignClear", 32'(misalignErr), 32'd0);
        pushFetch(32'h200);
        reqReady = 1'b1;
        tick();
        reqReady = 1'b0;
        checkOutput("misalignSeqAddr", reqAddr, 32'h204);

        // Reach the top of the address space, then handshake under stall.
        applyStimulus(32'hFFFF_FFFC);
        pushFetch(32'h204);
        reqReady = 1'b1;
        tick();
        reqReady = 1'b0;
        checkOutput("topAddr", reqAddr, 32'hFFFF_FFFC);
        checkOutput("wrapPlus4", pcPlus4, 32'h0);
        stallIn = 1'b1;
        pushFetch(32'hFFFF_FFFC);
        reqReady = 1'b1;
        tick();
        reqReady = 1'b0;
        checkOutput("stallValid", 32'(reqValid), 32'd0);
        checkOutput("wrapPc", pcOut, 32'h0);
        tick();
        checkOutput("stallHoldValid", 32'(reqValid), 32'd0);
        checkOutput("stallHoldPc", pcOut, 32'h0);
        stallIn = 1'b0;
        tick();
        checkOutput("resumeValid", 32'(reqValid), 32'd1);
        checkOutput("resumeAddr", reqAddr, 32'h0);

        // Build up a pending redirect, then reset asynchronously mid-request.
        applyStimulus(32'h400);
        checkOutput("preResetPend", 32'(redirectPending), 32'd1);
        checkCounters("preReset");
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        expFetches = 0;
        expRedirects = 0;
        checkOutput("asyncValid", 32'(reqValid), 32'd0);
        checkOutput("asyncPend", 32'(redirectPending), 32'd0);
        checkOutput("asyncPc", pcOut, 32'h0);
        checkOutput("asyncMisalign", 32'(misalignErr), 32'd0);
        checkCounters("async");
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
